// File: rtl/wb_ram_burst_pkg.sv
// +----------------------------------------------------------------------------+
// | wb_ram_burst_pkg : shared Wishbone cycle/burst encodings and FSM states    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package wb_ram_burst_pkg;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_END  = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_BEAT  = 2'd2,
        ST_BURST = 2'd3
    } state_t;

    // Bits of the beat index that wrap; zero means a linear burst.
    function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
        case (bte)
            BTE_LINEAR: return 4'h0;
            BTE_WRAP4:  return 4'h3;
            BTE_WRAP8:  return 4'h7;
            BTE_WRAP16: return 4'hf;
            default:    return 4'h0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_ram_burst_addr_gen.sv
// +----------------------------------------------------------------------------+
// | wb_ram_burst_addr_gen : beat address register with linear/wrap stepping    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_ram_burst_addr_gen
    import wb_ram_burst_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [31:0]   load_adr,
    input  logic          advance,
    input  logic [1:0]    bte,
    output logic [31:0]   adr,
    output logic [AW-1:0] next_idx
);

    localparam int          BW   = $clog2(DW / 8);
    localparam logic [31:0] STEP = 32'(DW / 8);

    logic [3:0]  mask;
    logic [3:0]  idx;
    logic [3:0]  idx_inc;
    logic [31:0] stepped;
    logic [31:0] adr_d;

    always_comb begin
        mask    = wrap_mask(bte);
        idx     = adr[BW +: 4];
        idx_inc = idx + 4'd1;
        if (mask == 4'h0) begin
            stepped = adr + STEP;
        end else begin
            stepped = {adr[31:BW+4], (idx & ~mask) | (idx_inc & mask), adr[BW-1:0]};
        end

        if (load) begin
            adr_d = load_adr & ~(STEP - 32'd1);
        end else if (advance) begin
            adr_d = stepped;
        end else begin
            adr_d = adr;
        end
    end

    // The RAM is read from adr_d so data for the next beat is ready one cycle early.
    assign next_idx = adr_d[BW +: AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr <= 32'd0;
        end else begin
            adr <= adr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_ram_burst.sv
// +----------------------------------------------------------------------------+
// | wb_ram_burst : Wishbone B4 RAM slave with wait states, CTI/BTE bursts,     |
// |                error on out-of-range access, console and test-pass MMIO    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module wb_ram_burst
    import wb_ram_burst_pkg::*;
#(
    parameter int          DW           = 32,
    parameter int          DEPTH        = 131072,
    parameter int          WAIT_STATES  = 0,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
    parameter logic [31:0] PASS_VALUE   = 32'd123456789
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic [31:0]     wb_adr_i,
    input  logic [DW-1:0]   wb_dat_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic            wb_we_i,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic [2:0]      wb_cti_i,
    input  logic [1:0]      wb_bte_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o,
    output logic            console_valid,
    output logic [7:0]      console_data,
    output logic            tests_passed
);

    localparam int          NB         = DW / 8;
    localparam int          BW         = $clog2(NB);
    localparam int          WORDS      = DEPTH / NB;
    localparam int          AW         = $clog2(WORDS);
    localparam logic [31:0] ALIGN_MASK = ~(32'(NB) - 32'd1);
    localparam logic [2:0]  WS         = 3'(WAIT_STATES);

    state_t        state;
    state_t        state_d;
    logic [2:0]    wait_cnt;
    logic [2:0]    wait_cnt_d;
    logic          burst_q;
    logic [1:0]    bte_q;

    logic [31:0]   beat_adr;
    logic [AW-1:0] rd_idx;
    logic [DW-1:0] rd_q;
    logic [DW-1:0] mem [WORDS];

    logic          req;
    logic          in_beat;
    logic          hit_con;
    logic          hit_pass;
    logic          hit_ram;
    logic          bad;
    logic          mem_we;

    assign req      = wb_cyc_i & wb_stb_i;
    assign in_beat  = ((state == ST_BEAT) || (state == ST_BURST)) && req;
    assign hit_con  = (beat_adr == (CONSOLE_ADDR & ALIGN_MASK));
    assign hit_pass = (beat_adr == (PASS_ADDR & ALIGN_MASK));
    assign hit_ram  = (beat_adr < 32'(DEPTH)) && !hit_con && !hit_pass;
    assign bad      = !hit_ram && !hit_con && !hit_pass;

    // Termination is decoded from state so an async reset removes it at once.
    assign wb_ack_o = in_beat & ~bad;
    assign wb_err_o = in_beat & bad;
    assign wb_dat_o = (wb_ack_o && hit_ram) ? rd_q : '0;
    assign mem_we   = wb_ack_o & wb_we_i & hit_ram;

    wb_ram_burst_addr_gen #(
        .DW (DW),
        .AW (AW)
    ) u_addr_gen (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_i),
        .load     ((state == ST_IDLE) && req),
        .load_adr (wb_adr_i),
        .advance  (wb_ack_o),
        .bte      (bte_q),
        .adr      (beat_adr),
        .next_idx (rd_idx)
    );

    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    wait_cnt_d = WS;
                    state_d    = (WS != 3'd0) ? ST_WAIT : ST_BEAT;
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt <= 3'd1) begin
                    state_d = ST_BEAT;
                end else begin
                    wait_cnt_d = wait_cnt - 3'd1;
                end
            end
            ST_BEAT: begin
                if (!wb_cyc_i || wb_err_o) begin
                    state_d = ST_IDLE;
                end else if (wb_ack_o) begin
                    state_d = (burst_q && (wb_cti_i == CTI_INCR)) ? ST_BURST : ST_IDLE;
                end
            end
            ST_BURST: begin
                if (!wb_cyc_i || wb_err_o) begin
                    state_d = ST_IDLE;
                end else if (wb_ack_o && (wb_cti_i != CTI_INCR)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state         <= ST_IDLE;
            wait_cnt      <= 3'd0;
            burst_q       <= 1'b0;
            bte_q         <= BTE_LINEAR;
            console_valid <= 1'b0;
            console_data  <= 8'd0;
            tests_passed  <= 1'b0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            if ((state == ST_IDLE) && req) begin
                burst_q <= (wb_cti_i == CTI_INCR);
                bte_q   <= wb_bte_i;
            end
            console_valid <= wb_ack_o & wb_we_i & hit_con;
            if (wb_ack_o && wb_we_i && hit_con) begin
                console_data <= wb_dat_i[7:0];
            end
            if (wb_ack_o && wb_we_i && hit_pass && (wb_dat_i[31:0] == PASS_VALUE)) begin
                tests_passed <= 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        rd_q <= mem[rd_idx];
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (wb_sel_i[i]) begin
                    mem[beat_adr[BW +: AW]][8*i +: 8] <= wb_dat_i[8*i +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire
